// File: rtl/serial_adder_ctrl_pkg.sv
// serial_adder_ctrl_pkg: shared state encoding for the bit-serial adder controller
package serial_adder_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell: 1-bit full adder from two half adders and an OR for carry
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);
  logic w_s1, w_c1, w_c2;
  half_adder u_ha0 (.a(a),    .b(b),   .sum(w_s1), .carry(w_c1));
  half_adder u_ha1 (.a(w_s1), .b(cin), .sum(sum),  .carry(w_c2));
  assign carry = w_c1 | w_c2;
endmodule

// File: rtl/half_adder.sv
// half_adder: single-bit half adder
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: sequences one full-adder cell over WIDTH bits, LSB first
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a_sh, r_b_sh, r_acc;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic             w_s_bit, w_c_next, w_last, w_accept, w_in_add;
  full_adder_cell u_fa (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .cin  (r_carry),
    .sum  (w_s_bit),
    .carry(w_c_next)
  );
  assign w_in_add = (r_state == ST_ADD);
  assign w_last   = w_in_add && (r_cnt == CNT_W'(WIDTH - 1));
  assign w_accept = (r_state == ST_IDLE) && start;
  // next state: IDLE->ADD on start, ADD->DONE on last bit, DONE->IDLE always
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = w_accept ? ST_ADD :
                  w_last ? ST_DONE :
                  (r_state == ST_DONE) ? ST_IDLE : r_state;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end
  // operand capture, bit-serial shift datapath and carry register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a_sh  <= a;
      r_b_sh  <= b;
      r_acc   <= '0;
      r_carry <= cin;
      r_cnt   <= '0;
    end else if (w_in_add) begin
      r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
      r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
      r_acc   <= {w_s_bit, r_acc[WIDTH-1:1]};
      r_carry <= w_c_next;
      r_cnt   <= w_last ? r_cnt : r_cnt + CNT_W'(1);
    end
  end
  // registered status and result; result only moves on the completion edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      busy <= w_accept || (w_in_add && !w_last);
      done <= w_last;
      if (w_last) begin
        sum  <= {w_s_bit, r_acc[WIDTH-1:1]};
        cout <= w_c_next;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: scoreboard bench for the bit-serial adder controller
module tb_serial_adder_ctrl;
  localparam int WIDTH = 8;
  logic             clk, rst_n, start, cin;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, cout;
  logic [WIDTH-1:0] sum;
  int               n_checks, n_fail, n_done;
  logic [WIDTH:0]   q[$];
  logic [WIDTH:0]   last_res;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // monitor: every done pulse must match the oldest pending expectation
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        n_done++;
        if (q.size() == 0) check("unexpected_done", 64'(1), 64'(0));
        else check("result", 64'({cout, sum}), 64'(q.pop_front()));
      end
    end
  end

  task automatic start_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic tc,
                          input logic [WIDTH:0] exp);
    @(posedge clk);
    #1;
    a = ta; b = tb_; cin = tc; start = 1'b1;
    q.push_back(exp);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // mode 0: plain, 1: scramble operands during ADD, 2: also poke start in ADD/DONE
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic tc,
                        input logic [WIDTH:0] exp, input int mode);
    int  nb;
    bit  got;
    nb = 0;
    got = 0;
    start_op(ta, tb_, tc, exp);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
      if (busy) nb++;
      if (mode != 0) begin
        check("sum_hold", 64'({cout, sum}), 64'(last_res));
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        cin = 1'($urandom);
        start = (mode == 2) && (nb == 3 || nb == 8);
      end
    end
    start = 1'b0;
    check("done_seen", 64'(got), 64'(1));
    check("busy_cycles", 64'(nb), 64'(WIDTH));
    last_res = exp;
    if (mode == 2) begin
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("ignored_start_busy", 64'(busy), 64'(0));
      check("ignored_start_res", 64'({cout, sum}), 64'(last_res));
    end
  endtask

  initial begin
    int nd, last_i;
    n_checks = 0; n_fail = 0; n_done = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    last_res = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 64'({busy, done, cout, sum}), 64'(0));
    rst_n = 1'b1;
    run_op(8'h00, 8'h00, 1'b0, 9'h000, 0);
    run_op(8'hA5, 8'h5A, 1'b1, 9'h100, 1);
    run_op(8'hFF, 8'h01, 1'b0, 9'h100, 0);
    run_op(8'h3C, 8'h0F, 1'b0, 9'h04B, 2);
    start_op(8'h77, 8'h11, 1'b0, 9'h088);
    repeat (4) @(negedge clk);
    check("pre_reset_busy", 64'(busy), 64'(1));
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    check("async_reset_outputs", 64'({busy, done, cout, sum}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    last_res = '0;
    @(negedge clk);
    check("post_reset_idle", 64'({busy, done, cout, sum}), 64'(0));
    run_op(8'h10, 8'h20, 1'b0, 9'h030, 1);
    @(posedge clk);
    #1;
    a = 8'h81; b = 8'h81; cin = 1'b0; start = 1'b1;
    repeat (3) q.push_back(9'h102);
    nd = 0;
    last_i = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        if (nd > 0) check("b2b_spacing", 64'(i - last_i), 64'(WIDTH + 2));
        last_i = i;
        nd++;
        if (nd == 3) begin
          start = 1'b0;
          break;
        end
      end
    end
    check("b2b_done_count", 64'(nd), 64'(3));
    repeat (4) @(negedge clk);
    check("final_idle", 64'(busy), 64'(0));
    check("queue_drained", 64'(q.size()), 64'(0));
    check("total_done_pulses", 64'(n_done), 64'(8));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
